// File: rtl/sig_dump_pkg.sv
// Shared types and default pointer addresses for the signature dump controller.
// Testbenches reuse the pointer constants so they track the design defaults.
package sig_dump_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SWEEP = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5,
        TOUT  = 3'd6
    } state_e;

    localparam logic [31:0] DEF_BEGIN_PTR = 32'h0000_3FF0;
    localparam logic [31:0] DEF_END_PTR   = 32'h0000_3FF4;

endpackage

// File: rtl/sig_watchdog.sv
// Enabled up-counter that pulses tc while enabled at count LIMIT-1.
// The owner leaves the counting state on tc, so the counter never needs to saturate.
module sig_watchdog #(
    parameter int unsigned LIMIT = 40000
) (
    input  logic clk,
    input  logic rst_b,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    assign tc = en && (count == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/sig_dump_ctrl.sv
// Snoops signature pointer stores, then streams memory [begin, end) out one word at a time.
// Handshake: a word transfers on a clock edge where sig_valid && sig_ready; while sig_valid is high and sig_ready low, sig_data/sig_last hold.
module sig_dump_ctrl
    import sig_dump_pkg::*;
#(
    parameter logic [31:0] BEGIN_PTR = DEF_BEGIN_PTR,
    parameter logic [31:0] END_PTR   = DEF_END_PTR,
    parameter logic [31:0] MIN_BEGIN = 32'd16,
    parameter int unsigned TIMEOUT   = 40000,
    parameter int          AW        = 22
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          dbus_wr,
    input  logic [31:0]   dbus_addr,
    input  logic [31:0]   dbus_wdata,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rdata,
    output logic          sig_valid,
    input  logic          sig_ready,
    output logic [31:0]   sig_data,
    output logic          sig_last,
    output logic          done,
    output logic          error,
    output logic          timeout,
    output state_e        dbg_state
);

    state_e        state, state_nxt;
    logic [31:0]   begin_q, end_q;
    logic [AW-1:0] cur, cur_plus4;
    logic          snoop, wr_begin, trigger, ptr_ok, last_calc, wd_tc;

    // Only IDLE listens to the bus; the sweep and terminal states work from latched pointers.
    assign snoop     = (state == IDLE);
    assign wr_begin  = snoop && dbus_wr && (dbus_addr == BEGIN_PTR);
    assign trigger   = snoop && dbus_wr && (dbus_addr == END_PTR);
    assign ptr_ok    = (dbus_wdata > begin_q) && (begin_q > MIN_BEGIN);
    assign cur_plus4 = cur + AW'(4);
    assign last_calc = (32'(cur) + 32'd4) >= end_q;

    sig_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
        .clk   (clk),
        .rst_b (rst_b),
        .en    (state == IDLE),
        .tc    (wd_tc)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // A trigger in the same cycle as the watchdog terminal count wins.
                if (trigger)    state_nxt = ptr_ok ? SWEEP : FAULT;
                else if (wd_tc) state_nxt = TOUT;
            end
            SWEEP: state_nxt = WAIT;
            WAIT:  state_nxt = OUT;
            OUT: begin
                if (sig_ready) state_nxt = sig_last ? DONE : SWEEP;
            end
            DONE, FAULT, TOUT: state_nxt = state;
            default:           state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            begin_q  <= '0;
            end_q    <= '0;
            cur      <= '0;
            sig_data <= '0;
            sig_last <= 1'b0;
        end else begin
            if (wr_begin) begin_q <= dbus_wdata;
            if (trigger) begin
                end_q <= dbus_wdata;
                cur   <= {begin_q[AW-1:2], 2'b00};
            end
            if (state == WAIT) begin
                sig_data <= mem_rdata;
                sig_last <= last_calc;
            end
            if (state == OUT && sig_ready && !sig_last) cur <= cur_plus4;
        end
    end

    assign mem_rd    = (state == SWEEP);
    assign mem_addr  = cur;
    assign sig_valid = (state == OUT);
    assign done      = (state == DONE);
    assign error     = (state == FAULT);
    assign timeout   = (state == TOUT);
    assign dbg_state = state;

endmodule
